// File: rtl/vga_sync_decoder_pkg.sv
// Shared timing constants and lock-FSM state encoding for the VGA sync decoder.
// Defaults describe the 1024x768 mode produced by VGA_Controller
// (1368 clocks per line, 806 lines per frame).
package vga_sync_decoder_pkg;

   localparam int   COUNTER_SIZE_DEF    = 11;
   localparam int   THRESHOLD_HSYNC_DEF = 1024;
   localparam int   THRESHOLD_VSYNC_DEF = 768;
   localparam int   WHOLE_LINE_DEF      = 1368;
   localparam int   WHOLE_FRAME_DEF     = 806;
   localparam logic SYNC_POLARITY_DEF   = 1'b1;
   localparam int   LOCK_FRAMES_DEF     = 2;

   typedef enum logic [1:0] {
      ST_SEARCH  = 2'd0,
      ST_MEASURE = 2'd1,
      ST_LOCKED  = 2'd2
   } lock_state_e;

endpackage

// File: rtl/vga_sync_decoder_edge.sv
// Sync input conditioning: registers the raw sync pin once, keeps the previous
// sample, normalises polarity and flags the asserted->deasserted transition.
// Ports:
//   clk_i       pixel clock
//   rst_i       asynchronous active-high reset
//   sync_i      raw sync pin
//   trailing_o  high for one cycle, the cycle after the pin deasserts
module vga_sync_decoder_edge
   import vga_sync_decoder_pkg::*;
#(
   parameter logic SYNC_POLARITY = SYNC_POLARITY_DEF
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic sync_i,
   output logic trailing_o
);

   logic in_q;
   logic prev_q;

   // Both samples reset to the deasserted level so releasing reset while the
   // pin is asserted never produces a spurious trailing edge.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         in_q   <= ~SYNC_POLARITY;
         prev_q <= ~SYNC_POLARITY;
      end else begin
         in_q   <= sync_i;
         prev_q <= in_q;
      end
   end

   assign trailing_o = (prev_q == SYNC_POLARITY) && (in_q != SYNC_POLARITY);

endmodule

// File: rtl/vga_sync_decoder.sv
// VGA timing sink: recovers pixel_x/pixel_y/active_video from h_sync/v_sync,
// measures line and frame length and declares lock after LOCK_FRAMES
// consecutive frames with the expected timing.
// Ports:
//   control_clock  pixel clock          control_reset  async active-high reset
//   h_sync/v_sync  sync inputs          pixel_x/y      position since trailing edges
//   active_video   inside visible area  line_length    last clocks per line
//   frame_lines    last lines per frame locked         timing stable
//   timing_error   one-cycle pulse when lock is lost
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_SEARCH  | waiting for a v trailing edge to start a whole frame
// ST_MEASURE | checking whole frames, counting consecutive good ones
// ST_LOCKED  | timing confirmed; any miss or timeout drops back to search
module vga_sync_decoder
   import vga_sync_decoder_pkg::*;
#(
   parameter int   COUNTER_SIZE    = COUNTER_SIZE_DEF,
   parameter int   THRESHOLD_HSYNC = THRESHOLD_HSYNC_DEF,
   parameter int   THRESHOLD_VSYNC = THRESHOLD_VSYNC_DEF,
   parameter int   WHOLE_LINE      = WHOLE_LINE_DEF,
   parameter int   WHOLE_FRAME     = WHOLE_FRAME_DEF,
   parameter logic SYNC_POLARITY   = SYNC_POLARITY_DEF,
   parameter int   LOCK_FRAMES     = LOCK_FRAMES_DEF
) (
   input  logic                    control_clock,
   input  logic                    control_reset,
   input  logic                    h_sync,
   input  logic                    v_sync,
   output logic [COUNTER_SIZE-1:0] pixel_x,
   output logic [COUNTER_SIZE-1:0] pixel_y,
   output logic                    active_video,
   output logic [COUNTER_SIZE-1:0] line_length,
   output logic [COUNTER_SIZE-1:0] frame_lines,
   output logic                    locked,
   output logic                    timing_error
);

   localparam int CW   = COUNTER_SIZE;
   localparam int CNTW = $clog2(LOCK_FRAMES + 1);

   localparam logic [CW-1:0]   CNT_MAX = '1;
   localparam logic [CW-1:0]   TH_C    = CW'(THRESHOLD_HSYNC);
   localparam logic [CW-1:0]   TV_C    = CW'(THRESHOLD_VSYNC);
   localparam logic [CW-1:0]   WL_C    = CW'(WHOLE_LINE);
   localparam logic [CW-1:0]   WF_C    = CW'(WHOLE_FRAME);
   localparam logic [CNTW-1:0] LOCK_N  = CNTW'(LOCK_FRAMES);

   logic h_trail, v_trail;

   vga_sync_decoder_edge #(.SYNC_POLARITY(SYNC_POLARITY)) u_h_edge (
      .clk_i      (control_clock),
      .rst_i      (control_reset),
      .sync_i     (h_sync),
      .trailing_o (h_trail)
   );

   vga_sync_decoder_edge #(.SYNC_POLARITY(SYNC_POLARITY)) u_v_edge (
      .clk_i      (control_clock),
      .rst_i      (control_reset),
      .sync_i     (v_sync),
      .trailing_o (v_trail)
   );

   logic [CW-1:0]   x_q, x_d, y_q, y_d, ll_q, ll_d, fl_q, fl_d;
   logic [CW-1:0]   x_inc, y_inc;
   logic            av_q, av_d;
   lock_state_e     state_q, state_d;
   logic [CNTW-1:0] cnt_q, cnt_d, cnt_inc;
   logic            miss_q, miss_d;
   logic            locked_q, err_q, err_d;
   logic            line_bad, frame_bad, timeout;

   // Saturating increments; these are also the measured lengths (count + 1).
   assign x_inc   = (x_q == CNT_MAX) ? x_q : x_q + CW'(1);
   assign y_inc   = (y_q == CNT_MAX) ? y_q : y_q + CW'(1);
   assign cnt_inc = cnt_q + CNTW'(1);

   always_comb begin
      x_d  = x_inc;
      y_d  = y_q;
      ll_d = ll_q;
      fl_d = fl_q;
      if (h_trail) begin
         ll_d = x_inc;
         x_d  = '0;
         y_d  = y_inc;
      end
      // Applied after the h update so a coincident v edge restarts the frame.
      if (v_trail) begin
         fl_d = y_inc;
         y_d  = '0;
      end
      av_d = (x_d < TH_C) && (y_d < TV_C);
   end

   assign line_bad  = h_trail && (x_inc != WL_C);
   assign frame_bad = v_trail && (y_inc != WF_C);
   assign timeout   = (x_q == CNT_MAX) || (y_q == CNT_MAX);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      miss_d  = miss_q;
      err_d   = 1'b0;
      case (state_q)
         ST_SEARCH: begin
            if (v_trail) begin
               state_d = ST_MEASURE;
               cnt_d   = '0;
               miss_d  = 1'b0;
            end
         end
         ST_MEASURE: begin
            if (timeout) begin
               state_d = ST_SEARCH;
               cnt_d   = '0;
            end else if (v_trail) begin
               // A coincident h edge closes the last line of this frame.
               miss_d = 1'b0;
               if (miss_q || line_bad || frame_bad) begin
                  cnt_d = '0;
               end else if (cnt_inc == LOCK_N) begin
                  state_d = ST_LOCKED;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_inc;
               end
            end else if (line_bad) begin
               miss_d = 1'b1;
            end
         end
         ST_LOCKED: begin
            if (line_bad || frame_bad || timeout) begin
               err_d   = 1'b1;
               state_d = ST_SEARCH;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = ST_SEARCH;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge control_clock or posedge control_reset) begin
      if (control_reset) begin
         x_q      <= '0;
         y_q      <= '0;
         ll_q     <= '0;
         fl_q     <= '0;
         av_q     <= 1'b0;
         state_q  <= ST_SEARCH;
         cnt_q    <= '0;
         miss_q   <= 1'b0;
         locked_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         x_q      <= x_d;
         y_q      <= y_d;
         ll_q     <= ll_d;
         fl_q     <= fl_d;
         av_q     <= av_d;
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         miss_q   <= miss_d;
         locked_q <= (state_d == ST_LOCKED);
         err_q    <= err_d;
      end
   end

   assign pixel_x      = x_q;
   assign pixel_y      = y_q;
   assign active_video = av_q;
   assign line_length  = ll_q;
   assign frame_lines  = fl_q;
   assign locked       = locked_q;
   assign timing_error = err_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder using a scaled-down mode (20 clocks x 12 lines,
// 16x8 visible, 6-bit counters) so whole frames and counter saturation are short.
module tb_vga_sync_decoder;

   localparam int CW   = 6;
   localparam int TH   = 16;
   localparam int TV   = 8;
   localparam int WL   = 20;
   localparam int WF   = 12;
   localparam int HS   = 2;
   localparam int VS   = 2;
   localparam int LF   = 2;
   localparam int MAXV = (1 << CW) - 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic h_pin = 1'b0;
   logic v_pin = 1'b0;
   logic [CW-1:0] pixel_x, pixel_y, line_length, frame_lines;
   logic active_video, locked, timing_error;

   always #5 clk = ~clk;

   vga_sync_decoder #(
      .COUNTER_SIZE(CW), .THRESHOLD_HSYNC(TH), .THRESHOLD_VSYNC(TV),
      .WHOLE_LINE(WL), .WHOLE_FRAME(WF), .SYNC_POLARITY(1'b1), .LOCK_FRAMES(LF)
   ) dut (
      .control_clock(clk), .control_reset(rst), .h_sync(h_pin), .v_sync(v_pin),
      .pixel_x(pixel_x), .pixel_y(pixel_y), .active_video(active_video),
      .line_length(line_length), .frame_lines(frame_lines),
      .locked(locked), .timing_error(timing_error)
   );

   int n_chk = 0;
   int n_fail = 0;

   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         if (n_fail <= 40) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic int imin(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   // Timestamp model: j counts rising edges; a pin that falls before edge k is
   // visible to the counters at edge k+1. Positions are distances to the last
   // applied edge, clipped at the counter ceiling.
   int j = 0;
   int th = 0, tv = 0, nh = 0, m_ll = 0, m_fl = 0, y_old = 0;
   bit s1h = 0, s2h = 0, s1v = 0, s2v = 0, av_zero = 1, m_ht, m_vt;
   int v_trail_j[$];

   always @(posedge clk) begin
      j++;
      if (rst) begin
         th = j; tv = j; nh = 0; m_ll = 0; m_fl = 0;
         s1h = 0; s2h = 0; s1v = 0; s2v = 0; av_zero = 1;
      end else begin
         m_ht  = s2h && !s1h;
         m_vt  = s2v && !s1v;
         y_old = imin(nh, MAXV);
         if (m_ht) begin
            m_ll = imin(j - th, MAXV);
            th   = j;
            nh   = imin(nh + 1, MAXV);
         end
         if (m_vt) begin
            m_fl = imin(y_old + 1, MAXV);
            tv   = j;
            nh   = 0;
            v_trail_j.push_back(j);
         end
         s2h = s1h; s1h = h_pin;
         s2v = s1v; s1v = v_pin;
         av_zero = 0;
      end
   end

   int ex, ey, eav, ell, efl;
   int n_err = 0, err_locked = 0, err_x = 0;
   bit lk_prev = 0;
   int lock_rise[$];
   int rise_x = -1, rise_y = -1, rise_ll = -1, rise_fl = -1;
   bit counting = 0;
   int av_cnt = 0, max_x = 0, max_y = 0;

   always @(negedge clk) begin
      if (rst) begin
         ex = 0; ey = 0; eav = 0; ell = 0; efl = 0;
      end else begin
         ex  = imin(j - th, MAXV);
         ey  = imin(nh, MAXV);
         eav = (!av_zero && ex < TH && ey < TV) ? 1 : 0;
         ell = m_ll;
         efl = m_fl;
      end
      check("pixel_x", int'(pixel_x), ex);
      check("pixel_y", int'(pixel_y), ey);
      check("active_video", int'(active_video), eav);
      check("line_length", int'(line_length), ell);
      check("frame_lines", int'(frame_lines), efl);
      if (timing_error) begin
         n_err++;
         err_locked = int'(locked);
         err_x = int'(pixel_x);
      end
      if (locked && !lk_prev) begin
         lock_rise.push_back(j);
         rise_x = int'(pixel_x); rise_y = int'(pixel_y);
         rise_ll = int'(line_length); rise_fl = int'(frame_lines);
      end
      lk_prev = locked;
      if (counting) begin
         if (active_video) av_cnt++;
         if (int'(pixel_x) > max_x) max_x = int'(pixel_x);
         if (int'(pixel_y) > max_y) max_y = int'(pixel_y);
      end
   end

   task automatic step(input bit h, input bit v);
      @(posedge clk);
      #1;
      h_pin = h;
      v_pin = v;
   endtask

   // One frame: h asserted on the last HS clocks of each line, v asserted on
   // the last VS lines, so v deasserts together with h at the frame start.
   task automatic gen_frame(input int short_line);
      int len;
      for (int l = 0; l < WF; l++) begin
         len = (l == short_line) ? WL - 1 : WL;
         for (int c = 0; c < len; c++) step(c >= len - HS, l >= WF - VS);
      end
   endtask

   int e0, r0;

   initial begin
      // 1: reset held while syncs toggle
      for (int i = 0; i < 12; i++) step(i[0], i[1]);
      check("rst_locked", int'(locked), 0);
      check("rst_error", int'(timing_error), 0);
      check("rst_pixel_x", int'(pixel_x), 0);
      step(0, 0);
      rst = 1'b0;

      // 2: clean frames, lock on the third v trailing edge
      for (int f = 0; f < 4; f++) gen_frame(-1);
      check("lock_rises", lock_rise.size(), 1);
      check("v_trails_seen", v_trail_j.size(), 3);
      check("lock_at_third_vtrail", (lock_rise.size() > 0) ? lock_rise[0] : -1,
            (v_trail_j.size() > 2) ? v_trail_j[2] : -2);
      check("lock_line_length", rise_ll, WL);
      check("lock_frame_lines", rise_fl, WF);
      check("coincident_pixel_y", rise_y, 0);
      check("coincident_pixel_x", rise_x, 0);
      check("locked_after_frames", int'(locked), 1);
      check("no_error_clean", n_err, 0);

      // 3: one short line while locked
      e0 = n_err;
      r0 = lock_rise.size();
      gen_frame(5);
      check("short_line_err_pulses", n_err - e0, 1);
      check("locked_at_err", err_locked, 0);
      check("unlocked_after_short", int'(locked), 0);
      for (int f = 0; f < 4; f++) gen_frame(-1);
      check("relock_rises", lock_rise.size() - r0, 1);
      check("relocked", int'(locked), 1);
      check("no_extra_err", n_err - e0, 1);

      // 4: h_sync held deasserted
      e0 = n_err;
      for (int i = 0; i < 80; i++) step(0, 0);
      check("h_timeout_err_pulses", n_err - e0, 1);
      check("x_at_timeout_err", err_x, MAXV);
      check("x_saturated", int'(pixel_x), MAXV);
      check("unlocked_after_timeout", int'(locked), 0);

      // 5: active area of one locked frame
      for (int f = 0; f < 4; f++) gen_frame(-1);
      check("relocked_after_timeout", int'(locked), 1);
      e0 = n_err;
      counting = 1'b1;
      gen_frame(-1);
      counting = 1'b0;
      check("active_cycles", av_cnt, TH * TV);
      check("max_pixel_x", max_x, WL - 1);
      check("max_pixel_y", max_y, WF - 1);
      check("locked_frame_no_err", n_err - e0, 0);

      // 6: async reset mid-line
      for (int c = 0; c < 7; c++) step(0, 0);
      e0 = n_err;
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check("async_pixel_x", int'(pixel_x), 0);
      check("async_locked", int'(locked), 0);
      check("async_line_length", int'(line_length), 0);
      check("async_frame_lines", int'(frame_lines), 0);
      for (int i = 0; i < 3; i++) step(0, 0);
      rst = 1'b0;
      for (int i = 0; i < 6; i++) step(0, 0);
      check("async_no_err", n_err - e0, 0);
      check("async_still_unlocked", int'(locked), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
